// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: pin synchronisers, clock glitch filter, 11-bit frame
// decoder and an inter-edge timeout that drops half-received frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clkSync_q;
    logic [1:0]            dataSync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  filtClk_q;
    logic                  filtClk_d;
    logic                  bitEdge;
    logic                  dataBit;
    logic                  timeout;

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byteValid_q, byteValid_d;
    logic          frameErr_q, frameErr_d;

    // Two-flop synchronisers plus the filter history of the synced clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            filt_q     <= '1;
            filtClk_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
            filt_q     <= {filt_q[FILTER_LEN-2:0], clkSync_q[1]};
            filtClk_q  <= filtClk_d;
        end
    end

    // Filtered clock only moves once the whole history agrees; bitEdge marks its fall.
    always_comb begin
        filtClk_d = filtClk_q;
        if (&filt_q) begin
            filtClk_d = 1'b1;
        end else if (~|filt_q) begin
            filtClk_d = 1'b0;
        end
        bitEdge = filtClk_q & ~filtClk_d;
        dataBit = dataSync_q[1];
    end

    // Frame state, shift register, timeout counter and registered result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Next-state logic: a stalled frame times out before any edge is considered.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        timer_d     = (state_q == IDLE || bitEdge) ? '0 : timer_q + TW'(1);
        timeout     = (state_q != IDLE) && !bitEdge &&
                      (timer_q == TW'(TIMEOUT_CYCLES - 1));

        if (timeout) begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
            shift_d    = '0;
            timer_d    = '0;
        end else if (bitEdge) begin
            case (state_q)
                IDLE: begin
                    if (!dataBit) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {dataBit, shift_q[7:1]};
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = dataBit;
                    state_d  = STOP;
                end
                STOP: begin
                    if (dataBit && (^{shift_q, parity_q})) begin
                        byteValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_valid = byteValid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frameErr_q;

endmodule

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard event receiver: folds E0/F0 prefixes into make/break events
// and queues them in a first-word fall-through FIFO with a valid/ready drain.
module ps2_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [7:0]                        ev_code,
    output logic                              ev_ext,
    output logic                              ev_rel,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              frame_err,
    output logic                              overflow,
    input  logic                              ovf_clear
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic       rxValid;
    logic [7:0] rxByte;
    logic       rxErr;

    logic             extP_q, extP_d;
    logic             relP_q, relP_d;
    logic             pushReq;
    ps2_event_t       pushEv;
    ps2_event_t       mem_q [FIFO_DEPTH];
    ps2_event_t       headEv;
    logic [PW-1:0]    wrPtr_q, rdPtr_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rxValid),
        .byte_data  (rxByte),
        .frame_err  (rxErr)
    );

    // Prefix decoder: E0/F0 only arm flags, any other byte becomes an event.
    always_comb begin
        extP_d  = extP_q;
        relP_d  = relP_q;
        pushReq = 1'b0;
        pushEv  = '{ext: extP_q, rel: relP_q, code: rxByte};
        if (rxErr) begin
            extP_d = 1'b0;
            relP_d = 1'b0;
        end else if (rxValid) begin
            if (rxByte == PS2_EXT) begin
                extP_d = 1'b1;
            end else if (rxByte == PS2_REL) begin
                relP_d = 1'b1;
            end else begin
                pushReq = 1'b1;
                extP_d  = 1'b0;
                relP_d  = 1'b0;
            end
        end
    end

    // FIFO control: a pop in the same cycle frees room for a push into a full queue.
    always_comb begin
        full    = (count_q == LVL_W'(FIFO_DEPTH));
        empty   = (count_q == '0);
        pop     = !empty && ev_ready;
        push    = pushReq && (!full || pop);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (pushReq && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Prefix flags, FIFO pointers, level and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            extP_q  <= 1'b0;
            relP_q  <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            extP_q  <= extP_d;
            relP_q  <= relP_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
        end
    end

    // Event storage; contents are masked at the outputs while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= pushEv;
        end
    end

    assign headEv     = mem_q[rdPtr_q];
    assign ev_valid   = !empty;
    assign ev_code    = empty ? 8'h00 : headEv.code;
    assign ev_ext     = empty ? 1'b0 : headEv.ext;
    assign ev_rel     = empty ? 1'b0 : headEv.rel;
    assign fifo_level = count_q;
    assign frame_err  = rxErr;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_event_rx.sv
// Bench for ps2_event_rx: frames are driven on the pins and a transaction-level
// model of the prefix folding and event queue predicts the drain port.
module tb_ps2_event_rx;

    localparam int FL    = 8;
    localparam int TO    = 300;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int HALF  = 20;
    localparam int SETUP = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          ev_ready = 1'b0;
    logic          ovf_clear = 1'b0;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_rel;
    logic [LW-1:0] fifo_level;
    logic          frame_err;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    bit settling    = 1'b1;
    bit checking    = 1'b0;
    bit readyEn     = 1'b0;
    bit readyAlways = 1'b0;
    bit clearEn     = 1'b0;
    bit forceClear  = 1'b0;

    // Requests from the stimulus thread to the model: {bad, byte} per frame.
    logic [8:0] reqArr [512];
    int reqN    = 0;
    int reqDone = 0;
    int rstReq  = 0;
    int rstDone = 0;

    // Model state, written only by the model process.
    logic [9:0] mq [$];
    bit mExt = 1'b0;
    bit mRel = 1'b0;
    bit mOvf = 1'b0;
    int errSeen = 0;

    always #5 clk = ~clk;

    ps2_event_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_rel     (ev_rel),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badPar, input bit badStop);
        logic par;
        par = (~^b) ^ badPar;
        return {~badStop, par, b, 1'b0};
    endfunction

    function automatic logic [9:0] headNow();
        return {ev_ext, ev_rel, ev_code};
    endfunction

    // Model: apply finished frames, then mirror consumer pops and overflow clears.
    always @(posedge clk) begin
        if (rstDone != rstReq) begin
            mq.delete();
            mExt = 1'b0;
            mRel = 1'b0;
            mOvf = 1'b0;
            rstDone = rstReq;
        end
        while (reqDone < reqN) begin
            if (reqArr[reqDone][8]) begin
                mExt = 1'b0;
                mRel = 1'b0;
            end else if (reqArr[reqDone][7:0] == 8'hE0) begin
                mExt = 1'b1;
            end else if (reqArr[reqDone][7:0] == 8'hF0) begin
                mRel = 1'b1;
            end else begin
                if (mq.size() < DEPTH) mq.push_back({mExt, mRel, reqArr[reqDone][7:0]});
                else mOvf = 1'b1;
                mExt = 1'b0;
                mRel = 1'b0;
            end
            reqDone++;
        end
        if (ev_ready && mq.size() != 0) void'(mq.pop_front());
        if (ovf_clear) mOvf = 1'b0;
        if (frame_err) errSeen++;
    end

    // Compare the drain port against the model whenever no frame is in flight.
    always @(negedge clk) begin
        if (checking && !settling && reset_n) begin
            checkOutput("ev_valid", ev_valid, mq.size() != 0);
            checkOutput("fifo_level", fifo_level, mq.size());
            checkOutput("overflow", overflow, mOvf);
            checkOutput("head", headNow(), (mq.size() != 0) ? mq[0] : 10'h0);
        end
    end

    // Consumer side: ready and overflow-clear are quiet while a frame is in flight.
    initial begin
        forever begin
            @(negedge clk);
            ev_ready  = (!settling && readyEn) ?
                        (readyAlways ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            ovf_clear = !settling && (forceClear || (clearEn && ($urandom_range(0, 7) == 0)));
        end
    end

    task automatic submit(input logic [8:0] e);
        reqArr[reqN] = e;
        reqN++;
    endtask

    task automatic applyStimulus(input logic [10:0] fr, input int nBits, input bit measure, output int lat);
        lat = -1;
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (SETUP) @(negedge clk);
            ps2_clk = 1'b0;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (measure && i == nBits - 1 && lat < 0 && ev_valid) lat = c;
            end
            ps2_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit badPar, input bit badStop,
                            input bit measure, output int lat);
        int e0;
        e0 = errSeen;
        settling = 1'b1;
        applyStimulus(makeFrame(b, badPar, badStop), 11, measure, lat);
        repeat (FL + 8) @(negedge clk);
        submit({badPar | badStop, b});
        @(negedge clk);
        checkOutput("frame_err count", errSeen - e0, (badPar | badStop) ? 1 : 0);
        settling = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit badPar, input bit badStop);
        int d;
        sendByte(b, badPar, badStop, 1'b0, d);
    endtask

    task automatic drain();
        readyEn = 1'b1;
        readyAlways = 1'b1;
        repeat (2 * DEPTH + 4) @(negedge clk);
        readyEn = 1'b0;
        readyAlways = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("drained empty", ev_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int e0;
        int sel;
        logic [7:0] b;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset ev_valid", ev_valid, 1'b0);
        checkOutput("reset level", fifo_level, 0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        checkOutput("reset head", headNow(), 10'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checking = 1'b1;
        settling = 1'b0;

        // Single clean 1C frame, including stop-edge to ev_valid latency
        sendByte(8'h1C, 1'b0, 1'b0, 1'b1, lat);
        checkOutput("ev_valid latency", lat, FL + 4);
        checkOutput("1C head", headNow(), 10'h01C);
        checkOutput("1C level", fifo_level, 1);
        drain();

        // Extended release, then a plain make with no carried flags
        send(8'hE0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h75, 1'b0, 1'b0);
        checkOutput("E0F075 level", fifo_level, 1);
        checkOutput("E0F075 head", headNow(), 10'h375);
        send(8'h75, 1'b0, 1'b0);
        checkOutput("75 level", fifo_level, 2);
        drain();

        // Parity and stop errors, then a release that must not inherit anything
        send(8'hE0, 1'b0, 1'b0);
        send(8'h1C, 1'b1, 1'b0);
        send(8'h1C, 1'b0, 1'b1);
        checkOutput("err level", fifo_level, 0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        checkOutput("F01C head", headNow(), 10'h11C);
        drain();

        // Truncated frame recovered by timeout
        e0 = errSeen;
        settling = 1'b1;
        applyStimulus(makeFrame(8'hA5, 1'b0, 1'b0), 5, 1'b0, lat);
        ps2_data = 1'b1;
        repeat (TO + 40) @(negedge clk);
        checkOutput("timeout err", errSeen - e0, 1);
        submit(9'h100);
        @(negedge clk);
        settling = 1'b0;
        send(8'h29, 1'b0, 1'b0);
        checkOutput("29 head", headNow(), 10'h029);
        drain();

        // Overflow: DEPTH+1 events with no consumer
        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
        checkOutput("ovf level", fifo_level, DEPTH);
        checkOutput("ovf flag", overflow, 1'b1);
        checkOutput("ovf head", headNow(), 10'h010);
        drain();
        checkOutput("ovf kept", overflow, 1'b1);
        forceClear = 1'b1;
        repeat (2) @(negedge clk);
        forceClear = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("ovf cleared", overflow, 1'b0);

        // Short clock glitches while data is low must not start a frame
        e0 = errSeen;
        ps2_data = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (TO + 20) @(negedge clk);
        checkOutput("glitch err", errSeen - e0, 0);
        checkOutput("glitch level", fifo_level, 0);
        send(8'h5A, 1'b0, 1'b0);
        checkOutput("5A head", headNow(), 10'h05A);
        drain();

        // Reset in the middle of a frame with an event queued
        send(8'h33, 1'b0, 1'b0);
        settling = 1'b1;
        applyStimulus(makeFrame(8'h6B, 1'b0, 1'b0), 3, 1'b0, lat);
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL + 4) @(negedge clk);
        reset_n = 1'b0;
        rstReq++;
        #1;
        checkOutput("midreset ev_valid", ev_valid, 1'b0);
        checkOutput("midreset level", fifo_level, 0);
        checkOutput("midreset overflow", overflow, 1'b0);
        checkOutput("midreset frame_err", frame_err, 1'b0);
        checkOutput("midreset head", headNow(), 10'h0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (FL + 6) @(negedge clk);
        settling = 1'b0;
        send(8'h6B, 1'b0, 1'b0);
        checkOutput("6B head", headNow(), 10'h06B);
        drain();

        // Randomised traffic with a random consumer and occasional clears
        for (int f = 0; f < 40; f++) begin
            readyEn = 1'b1;
            clearEn = 1'b1;
            repeat ($urandom_range(1, 30)) @(negedge clk);
            sel = int'($urandom_range(0, 9));
            b = 8'($urandom_range(0, 255));
            case (sel)
                0:       send(8'hE0, 1'b0, 1'b0);
                1:       send(8'hF0, 1'b0, 1'b0);
                2:       send(b, 1'b1, 1'b0);
                3:       send(b, 1'b0, 1'b1);
                default: send(b, 1'b0, 1'b0);
            endcase
        end
        clearEn = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_event_rx.md
# ps2_event_rx

Parametrised PS/2 keyboard receiver, successor to the single-byte strobe interface:
- Adds a two-flop input synchroniser and a configurable clock glitch filter.
- Adds a frame timeout that resynchronises after a lost bit.
- Folds E0/F0 prefixes into per-key make/break events.
- Buffers events in a FIFO with a valid/ready drain port.

It sits between the board PS/2 pins and the keyboard-matrix encoder or a CPU-readable keyboard port.

## Interface
- `FILTER_LEN`, 8: consecutive equal synced samples required to change the filtered PS/2 clock (≥2).
- `TIMEOUT_CYCLES`, 5000: max `clk` cycles between falling edges inside a frame (≥2).
- `FIFO_DEPTH`, 8: event entries; power of two, ≥2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset; one clock domain.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `ev_valid` out 1: FIFO non-empty; head event presented.
- `ev_ready` in 1: consumer accepts head event when `ev_valid`.
- `ev_code` out 8: scan code of head event.
- `ev_ext` out 1: head event was preceded by E0.
- `ev_rel` out 1: head event was preceded by F0 (key release).
- `fifo_level` out $clog2(FIFO_DEPTH+1): current entry count.
- `frame_err` out 1: one-cycle pulse on parity, stop-bit or timeout error.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `ovf_clear` in 1: clears `overflow`.

## Operation
- **Sync:** two flops on each pin; both reset to 1.
- **Filter:**
  - `FILTER_LEN`-bit shift register of the synced clock, reset all-ones.
  - Filtered clock goes 1 when the register is all ones and 0 when it is all zeros; otherwise it holds. It resets to 1.
  - `bitedge` is high in the single cycle the filtered clock goes 1→0. Synced data is sampled in that cycle.
- **Frame FSM** (reset IDLE):
  - IDLE: `bitedge` with data=0 → DATA, bit count=0. Data=1 is ignored.
  - DATA: shift data in LSB first; after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if data=1 and the XOR of the 8 data bits and parity is 1 (odd), pulse `byte_valid`. Otherwise pulse `frame_err`. Always → IDLE.
- **Timeout:**
  - The counter clears on every `bitedge` and in IDLE, and counts otherwise.
  - Reaching `TIMEOUT_CYCLES` outside IDLE pulses `frame_err`, discards the partial byte, and returns to IDLE.
- **Prefix decoder:**
  - Pending flags `ext_p` and `rel_p`, both reset 0.
  - Byte E0 sets `ext_p`; byte F0 sets `rel_p`. Neither pushes an event.
  - Any other byte (including E1, AA, FA, EE) pushes {`ext_p`,`rel_p`,byte} and clears both flags.
  - `frame_err` clears both flags.
- **FIFO** (first-word fall-through, 10-bit entries):
  - Pop on `ev_valid && ev_ready`.
  - Push while full: dropped and `overflow` set, unless a pop occurs in the same cycle, in which case the push is accepted and the level is unchanged.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **`overflow`:** set has priority over a simultaneous `ovf_clear`.
- **Reset:** async assertion forces all state idle mid-frame: FSM IDLE, FIFO empty, flags 0, outputs 0.

## Timing
- **Reset values:**
  - `ev_valid`, `frame_err`, `overflow` = 0; `fifo_level` = 0.
  - `ev_code`, `ev_ext`, `ev_rel` = 0 (empty-FIFO head).
- Pin-to-`bitedge`: 2 sync cycles + `FILTER_LEN` samples after the pin settles.
- Stop-bit `bitedge` in cycle N: `byte_valid`/`frame_err` high in N+1. FIFO write at the end of N+1. `ev_valid` high from N+2 if the FIFO was empty.
- `fifo_level` updates the cycle after a push or pop.
- `ev_*` hold stable while `ev_valid && !ev_ready`.
- Pop at cycle M: the next entry, or `ev_valid`=0, is visible in M+1.

## Structure
- **Package `ps2_pkg`:**
  - localparams `PS2_EXT`=8'hE0 and `PS2_REL`=8'hF0.
  - enum `ps2_rx_state_t` {IDLE, DATA, PARITY, STOP}.
  - packed struct `ps2_event_t` {ext, rel, code[7:0]}.
- **Sub-module `ps2_frame_rx`:** sync, filter, frame FSM and timeout. Outputs `byte_valid`, `byte`, `frame_err`.
- **Top:** prefix decoder and FIFO, inline.

## Test plan
- Frame 1C with valid odd parity (P=0) and stop=1, FIFO empty → one event {ext=0,rel=0,code=1C}; `ev_valid` rises at N+2; `fifo_level`=1.
- Sequence E0 F0 75 → exactly one event {1,1,75}. Then 75 alone → {0,0,75}, with no flags carried over.
- Frame 1C with wrong parity; then a frame with stop=0 → two `frame_err` pulses, no events. A following F0 1C → {0,1,1C}.
- Send start+4 bits, then idle for `TIMEOUT_CYCLES` → one `frame_err`, FSM in IDLE. A following clean frame 29 → event {0,0,29}.
- Push `FIFO_DEPTH`+1 events with `ev_ready`=0 → level=8, `overflow`=1, last event lost. Drain → first 8 codes in order, then `ev_valid`=0. `ovf_clear` → `overflow`=0.
- 1-cycle and `FILTER_LEN`-1-cycle low glitches on `ps2_clk` in IDLE → no `bitedge`, no error. Assert `reset_n` mid-frame → all outputs zero, the next full frame decodes correctly.
